// File: rtl/ipsum_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ipsum_buffer
//  Brief    : Reloads partial sums from the GLB into per-row 4-deep FIFOs and
//             presents one ipsum per active row to the PE array on each pop.
//  Revision : 1.0 - initial release
// ============================================================================
module ipsum_buffer #(
    parameter int ROW_NUM = 32,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_f,
    input  logic [5:0]                row_en,
    input  logic [7:0]                round_num,
    input  logic                      valid_ip,
    output logic                      ready_ip,
    input  logic [2*DATA_W-1:0]       ipsum_in,
    input  logic                      pop_ipsum_f,
    output logic                      ipsum_valid,
    output logic [ROW_NUM*DATA_W-1:0] ipsum_out,
    output logic                      busy,
    output logic                      done
);

    localparam int c_ROW_W = $clog2(ROW_NUM);
    localparam int c_CNT_W = c_ROW_W + 1;
    localparam int c_POP_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_done_nxt;
    logic                 r_ready;
    logic                 r_done;
    logic [5:0]           r_row_en;
    logic [7:0]           r_round_num;
    logic [7:0]           r_round_cnt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_POP_W-1:0]   r_pop_cnt;

    logic                 w_start_ok;
    logic                 w_hs;
    logic                 w_last_word;
    logic                 w_pop;
    logic                 w_last_pop;
    logic                 w_last_round;
    logic [c_ROW_W-1:0]   w_row;

    assign w_start_ok   = start_f && (r_state == S_IDLE) && (row_en != 6'd0)
                          && ({1'b0, row_en} <= 7'(ROW_NUM)) && (round_num != 8'd0);
    assign w_hs         = valid_ip && r_ready;
    // Two words per row, so the final word index is 2*row_en-1.
    assign w_last_word  = (7'(r_cnt) == (({1'b0, r_row_en} << 1) - 7'd1));
    assign w_row        = r_cnt[c_CNT_W-1:1];
    assign w_pop        = (r_state == S_DRAIN) && pop_ipsum_f;
    assign w_last_pop   = w_pop && (r_pop_cnt == c_POP_W'(DEPTH - 1));
    assign w_last_round = ((r_round_cnt + 8'd1) >= r_round_num);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_FILL);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                if (w_hs && w_last_word) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    if (w_last_round) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_row_en    <= 6'd0;
            r_round_num <= 8'd0;
        end else if (w_start_ok) begin
            r_row_en    <= row_en;
            r_round_num <= round_num;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_start_ok) begin
            r_cnt <= '0;
        end else if (w_hs) begin
            r_cnt <= w_last_word ? '0 : r_cnt + 1'b1;
        end
    end

    // Pop counter wraps to zero on the final pop of a round.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pop_cnt <= '0;
        end else if (w_start_ok) begin
            r_pop_cnt <= '0;
        end else if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_round_cnt <= 8'd0;
        end else if (w_start_ok) begin
            r_round_cnt <= 8'd0;
        end else if (w_last_pop && !w_last_round) begin
            r_round_cnt <= r_round_cnt + 8'd1;
        end
    end

    assign ready_ip    = r_ready;
    assign ipsum_valid = (r_state == S_DRAIN);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;

    generate
        for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
            logic [DATA_W-1:0] r_fifo [DEPTH];
            logic              w_act;
            logic              w_sel;

            assign w_act = (7'(r) < {1'b0, r_row_en});
            assign w_sel = w_hs && (w_row == c_ROW_W'(r));

            // Even word fills the head pair, odd word the tail pair; upper half first.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
                end else if (w_sel) begin
                    if (!r_cnt[0]) begin
                        r_fifo[3] <= ipsum_in[2*DATA_W-1:DATA_W];
                        r_fifo[2] <= ipsum_in[DATA_W-1:0];
                    end else begin
                        r_fifo[1] <= ipsum_in[2*DATA_W-1:DATA_W];
                        r_fifo[0] <= ipsum_in[DATA_W-1:0];
                    end
                end else if (w_pop && w_act) begin
                    for (int i = DEPTH - 1; i > 0; i--) r_fifo[i] <= r_fifo[i-1];
                    r_fifo[0] <= '0;
                end
            end

            assign ipsum_out[r*DATA_W +: DATA_W] = (ipsum_valid && w_act) ? r_fifo[DEPTH-1] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ipsum_buffer.sv
`default_nettype none
// Testbench for ipsum_buffer: directed tables, hand sequences and randomized
// tiles compared against a word-to-row mapping model.
module tb_ipsum_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_f;
    logic [5:0]   row_en;
    logic [7:0]   round_num;
    logic         valid_ip;
    logic         ready_ip;
    logic [31:0]  ipsum_in;
    logic         pop_ipsum_f;
    logic         ipsum_valid;
    logic [511:0] ipsum_out;
    logic         busy;
    logic         done;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] words [64];

    typedef struct {
        int ren;
        int rnum;
        bit exp_busy;
    } start_vec_t;

    typedef struct {
        int          pop;
        int          row;
        logic [15:0] val;
    } fa_vec_t;

    start_vec_t sv [7];
    fa_vec_t    fa [8];

    always #5 clk = ~clk;

    ipsum_buffer #(.ROW_NUM(32), .DEPTH(4), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_f     (start_f),
        .row_en      (row_en),
        .round_num   (round_num),
        .valid_ip    (valid_ip),
        .ready_ip    (ready_ip),
        .ipsum_in    (ipsum_in),
        .pop_ipsum_f (pop_ipsum_f),
        .ipsum_valid (ipsum_valid),
        .ipsum_out   (ipsum_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Row r of a tile is loaded from words 2r and 2r+1, upper halves leaving first.
    function automatic logic [511:0] exp_vec(input int ren, input int p);
        logic [511:0] v;
        logic [31:0]  w;
        v = '0;
        for (int r = 0; r < 32; r++) begin
            if (r < ren) begin
                w = words[2*r + p/2];
                v[r*16 +: 16] = (p % 2 == 0) ? w[31:16] : w[15:0];
            end
        end
        return v;
    endfunction

    task automatic do_reset();
        reset       = 1'b0;
        start_f     = 1'b0;
        row_en      = 6'd0;
        round_num   = 8'd0;
        valid_ip    = 1'b0;
        ipsum_in    = 32'd0;
        pop_ipsum_f = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic start_tile(input int ren, input int rnum);
        start_f   = 1'b1;
        row_en    = 6'(ren);
        round_num = 8'(rnum);
        step();
        start_f   = 1'b0;
        row_en    = 6'($urandom);
        round_num = 8'($urandom);
        chk("start_busy", 512'(busy), 512'(1));
        chk("start_ready", 512'(ready_ip), 512'(1));
    endtask

    task automatic fill_round(input int ren, input int gap_max);
        for (int k = 0; k < 2*ren; k++) begin
            int gaps;
            gaps = $urandom_range(0, gap_max);
            for (int g = 0; g < gaps; g++) begin
                valid_ip    = 1'b0;
                ipsum_in    = $urandom;
                pop_ipsum_f = 1'($urandom);
                start_f     = 1'($urandom);
                step();
                chk("fill_gap_ready", 512'(ready_ip), 512'(1));
                chk("fill_gap_valid", 512'(ipsum_valid), 512'(0));
                chk("fill_gap_out", ipsum_out, 512'(0));
            end
            valid_ip    = 1'b1;
            ipsum_in    = words[k];
            pop_ipsum_f = 1'($urandom);
            start_f     = 1'($urandom);
            step();
            if (k < 2*ren - 1) begin
                chk("fill_ready", 512'(ready_ip), 512'(1));
                chk("fill_valid", 512'(ipsum_valid), 512'(0));
            end
        end
        start_f     = 1'b0;
        pop_ipsum_f = 1'b0;
        valid_ip    = 1'b0;
        chk("drain_entry_valid", 512'(ipsum_valid), 512'(1));
        chk("drain_entry_ready", 512'(ready_ip), 512'(0));
    endtask

    task automatic drain_round(input int ren, input bit last, input int wait_max);
        for (int p = 0; p < 4; p++) begin
            int waits;
            waits = $urandom_range(0, wait_max);
            for (int w = 0; w < waits; w++) begin
                valid_ip = 1'b1;
                ipsum_in = $urandom;
                step();
                chk("drain_wait_ready", 512'(ready_ip), 512'(0));
            end
            chk("drain_vec", ipsum_out, exp_vec(ren, p));
            pop_ipsum_f = 1'b1;
            valid_ip    = 1'($urandom);
            ipsum_in    = $urandom;
            step();
            pop_ipsum_f = 1'b0;
            valid_ip    = 1'b0;
            if (p < 3) chk("drain_no_done", 512'(done), 512'(0));
        end
        if (last) begin
            chk("done_pulse", 512'(done), 512'(1));
            chk("done_busy", 512'(busy), 512'(0));
            chk("done_ready", 512'(ready_ip), 512'(0));
            step();
            chk("done_clear", 512'(done), 512'(0));
            chk("idle_out", ipsum_out, 512'(0));
        end else begin
            chk("round_no_done", 512'(done), 512'(0));
            chk("round_refill_ready", 512'(ready_ip), 512'(1));
            chk("round_refill_valid", 512'(ipsum_valid), 512'(0));
        end
    endtask

    task automatic run_tile(input int ren, input int rnum, input int gap_max,
                            input int wait_max, input bit rnd);
        start_tile(ren, rnum);
        for (int rd = 0; rd < rnum; rd++) begin
            if (rnd) for (int k = 0; k < 64; k++) words[k] = $urandom;
            fill_round(ren, gap_max);
            drain_round(ren, rd == rnum - 1, wait_max);
        end
    endtask

    initial begin
        sv[0] = '{0, 1, 1'b0};
        sv[1] = '{33, 1, 1'b0};
        sv[2] = '{63, 5, 1'b0};
        sv[3] = '{1, 0, 1'b0};
        sv[4] = '{0, 0, 1'b0};
        sv[5] = '{32, 255, 1'b1};
        sv[6] = '{7, 2, 1'b1};

        fa[0] = '{0, 0, 16'h0001};
        fa[1] = '{0, 31, 16'h007D};
        fa[2] = '{0, 7, 16'h001D};
        fa[3] = '{1, 0, 16'h0000};
        fa[4] = '{1, 10, 16'h0028};
        fa[5] = '{2, 3, 16'h000F};
        fa[6] = '{3, 0, 16'h0002};
        fa[7] = '{3, 31, 16'h007E};

        // Reset, then idle with valid_ip held high.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid_ip = 1'b1;
            ipsum_in = $urandom;
            chk("rst_ready", 512'(ready_ip), 512'(0));
            chk("rst_valid", 512'(ipsum_valid), 512'(0));
            chk("rst_out", ipsum_out, 512'(0));
            chk("rst_busy", 512'(busy), 512'(0));
            chk("rst_done", 512'(done), 512'(0));
            step();
        end
        valid_ip = 1'b0;

        // Start legality table.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            start_f   = 1'b1;
            row_en    = 6'(sv[i].ren);
            round_num = 8'(sv[i].rnum);
            step();
            start_f = 1'b0;
            chk("start_tbl_busy", 512'(busy), 512'(sv[i].exp_busy));
            chk("start_tbl_ready", 512'(ready_ip), 512'(sv[i].exp_busy));
        end

        // Single row, known words.
        do_reset();
        words[0] = 32'h0004_0003;
        words[1] = 32'h0002_0001;
        start_tile(1, 1);
        valid_ip = 1'b1; ipsum_in = words[0]; step();
        chk("single_valid_early", 512'(ipsum_valid), 512'(0));
        ipsum_in = words[1]; step();
        valid_ip = 1'b0;
        chk("single_valid", 512'(ipsum_valid), 512'(1));
        for (int p = 0; p < 4; p++) begin
            logic [15:0] e;
            e = 16'(4 - p);
            chk("single_row0", 512'(ipsum_out[15:0]), 512'(e));
            chk("single_rows_hi", 512'(ipsum_out[511:16]), 512'(0));
            pop_ipsum_f = 1'b1; step(); pop_ipsum_f = 1'b0;
        end
        chk("single_done", 512'(done), 512'(1));
        step();
        chk("single_idle", 512'(busy), 512'(0));

        // Full array with table of known values.
        for (int k = 0; k < 64; k++) words[k] = {16'(2*k + 1), 16'(2*k)};
        start_tile(32, 1);
        fill_round(32, 0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++) begin
                if (fa[i].pop == p)
                    chk("full_tbl", 512'(ipsum_out[fa[i].row*16 +: 16]), 512'(fa[i].val));
            end
            chk("full_vec", ipsum_out, exp_vec(32, p));
            pop_ipsum_f = 1'b1; step(); pop_ipsum_f = 1'b0;
        end
        chk("full_done", 512'(done), 512'(1));
        step();

        // Backpressure, then multi-round with pops during fill.
        run_tile(4, 1, 2, 3, 1'b1);
        run_tile(2, 2, 1, 2, 1'b1);

        // Reset after 3 of 8 words.
        start_tile(4, 1);
        for (int k = 0; k < 3; k++) begin
            valid_ip = 1'b1; ipsum_in = $urandom; step();
        end
        reset = 1'b0; step(); reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_ready", 512'(ready_ip), 512'(0));
            chk("midrst_busy", 512'(busy), 512'(0));
            chk("midrst_valid", 512'(ipsum_valid), 512'(0));
            chk("midrst_out", ipsum_out, 512'(0));
            chk("midrst_done", 512'(done), 512'(0));
            step();
        end
        valid_ip = 1'b0;
        run_tile(3, 1, 1, 1, 1'b1);

        // Randomized tiles.
        for (int t = 0; t < 6; t++) begin
            run_tile($urandom_range(1, 32), $urandom_range(1, 3), 2, 2, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
